// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Op codes follow the decode-stage MULT/MULTU/DIV/DIVU numbering.
package mdu_pkg;

  localparam int MDU_DW   = 32;
  localparam int MDU_OP_W = 2;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Two-lane conditional negate; in wide mode the lanes
// form one double-width value negated as a whole.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic         wide,
  input  logic         neg_hi,
  input  logic         neg_lo,
  input  logic [W-1:0] x_hi,
  input  logic [W-1:0] x_lo,
  output logic [W-1:0] y_hi,
  output logic [W-1:0] y_lo
);

  logic [2*W-1:0] xw;
  logic [2*W-1:0] nw;

  assign xw = {x_hi, x_lo};
  assign nw = -xw;

  always_comb begin
    y_hi = x_hi;
    y_lo = x_lo;
    if (wide) begin
      if (neg_lo) begin
        y_hi = nw[2*W-1:W];
        y_lo = nw[W-1:0];
      end
    end else begin
      if (neg_hi) y_hi = -x_hi;
      if (neg_lo) y_lo = -x_lo;
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative shift-add multiply / restoring divide with
// architectural HI/LO registers and MTHI/MTLO writes.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = MDU_DW,
  parameter int OP_W       = MDU_OP_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [OP_W-1:0]       op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  hi_wen,
  input  logic                  lo_wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  mdu_state_e      state;
  logic [CW-1:0]   cnt;
  logic            is_div_q;
  logic            sa_q;
  logic            sb_q;
  logic            dz_q;
  logic [DW-1:0]   a_raw;
  logic [DW-1:0]   d;
  logic [2*DW-1:0] acc;

  logic            op_sgn;
  logic            op_sa;
  logic            op_sb;
  logic [DW-1:0]   ma;
  logic [DW-1:0]   mb;
  logic [DW-1:0]   rh;
  logic [DW-1:0]   rl;
  logic [DW:0]     shifted;
  logic [DW:0]     trial;
  logic [DW:0]     sum;

  assign op_sgn = ~op[0];
  assign op_sa  = op_sgn & a[DW-1];
  assign op_sb  = op_sgn & b[DW-1];
  assign busy   = (state != S_IDLE);

  mdu_sign_fix #(.W(DW)) u_opnd (
    .wide   (1'b0),
    .neg_hi (op_sa),
    .neg_lo (op_sb),
    .x_hi   (a),
    .x_lo   (b),
    .y_hi   (ma),
    .y_lo   (mb)
  );

  mdu_sign_fix #(.W(DW)) u_res (
    .wide   (~is_div_q),
    .neg_hi (is_div_q ? sa_q : (sa_q ^ sb_q)),
    .neg_lo (sa_q ^ sb_q),
    .x_hi   (acc[2*DW-1:DW]),
    .x_lo   (acc[DW-1:0]),
    .y_hi   (rh),
    .y_lo   (rl)
  );

  // Divide: remainder lives in acc upper half, quotient
  // shifts in from the bottom as the dividend shifts out.
  assign shifted = acc[2*DW-1:DW-1];
  assign trial   = shifted - {1'b0, d};
  assign sum     = {1'b0, acc[2*DW-1:DW]}
                 + (acc[0] ? {1'b0, d} : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      a_raw    <= '0;
      d        <= '0;
      acc      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hi_wen) hi <= wdata;
          if (lo_wen) lo <= wdata;
          if (start) begin
            is_div_q <= op[1];
            sa_q     <= op_sa;
            sb_q     <= op_sb;
            dz_q     <= op[1] && (b == '0);
            a_raw    <= a;
            cnt      <= '0;
            if (op[1]) begin
              d   <= mb;
              acc <= {{DW{1'b0}}, ma};
            end else begin
              d   <= ma;
              acc <= {{DW{1'b0}}, mb};
            end
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (is_div_q) begin
            if (trial[DW])
              acc <= {shifted[DW-1:0], acc[DW-2:0], 1'b0};
            else
              acc <= {trial[DW-1:0], acc[DW-2:0], 1'b1};
          end else begin
            acc <= {sum, acc[DW-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          if (dz_q) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= rh;
            lo <= rl;
          end
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the single-issue MIPS core. It sits in the execute stage beside the ALU. It accepts MULT/MULTU/DIV/DIVU from decode and holds the results in HI/LO. The writeback mux forwards HI or LO to the register-file write-data path for MFHI/MFLO. MTHI/MTLO write HI/LO directly.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width
OP_W, 2, width of op code

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  launch operation; sampled only when busy=0
op  in  OP_W  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with start
a  in  DATA_WIDTH  multiplicand / dividend (rs)
b  in  DATA_WIDTH  multiplier / divisor (rt)
hi_wen  in  1  MTHI write enable
lo_wen  in  1  MTLO write enable
wdata  in  DATA_WIDTH  MTHI/MTLO data
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse: HI/LO just updated by an operation
hi  out  DATA_WIDTH  HI register
lo  out  DATA_WIDTH  LO register

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE; hi, lo, done and the counter are cleared; busy=0 next cycle.
  - This applies mid-operation: the operation is abandoned and no done is produced.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE -> CALC on start=1; latch op, |a|, |b| and the sign flags. Signed ops take magnitudes; unsigned ops take raw values.
  - CALC: one iteration per cycle, counter 0..DATA_WIDTH-1. Exit to FIX when counter = DATA_WIDTH-1.
  - FIX: apply sign correction, then write hi/lo at the end of the cycle.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency: start sampled at edge N; CALC spans cycles N+1..N+32; FIX is N+33; DONE (done=1, new hi/lo visible) is N+34. The next start can be accepted at edge N+35.
- Multiply: shift-add on a 2*DATA_WIDTH accumulator, giving {hi,lo} = full 64-bit product.
  - MULT: negate the product if sign(a) XOR sign(b).
- Divide: restoring division on magnitudes, giving lo = quotient and hi = remainder.
  - DIV: quotient negated if sign(a) XOR sign(b); remainder takes the sign of a (truncating division).
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (b=0, DIV or DIVU): no exception. Fixed result lo=0xFFFFFFFF, hi=a (raw operand); same latency.
- start while busy=1: ignored, with no effect on the in-flight operation.
- hi_wen/lo_wen:
  - Honoured only when busy=0; hi/lo takes wdata at the edge. Ignored while busy.
  - If start arrives in the same IDLE cycle, the write takes effect and is later overwritten at FIX.
- hi/lo change only on reset, MTHI/MTLO in IDLE, or FIX. They hold their old values during CALC.
- Width rules: internal remainder DATA_WIDTH+1 bits for the trial subtract; counter $clog2(DATA_WIDTH) bits; all negation is two's complement modulo width.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULT/MDU_MULTU/MDU_DIV/MDU_DIVU;
  - state encodings;
  - DATA_WIDTH default.
- The core stays a single module. One natural sub-module, mdu_sign_fix (combinational pre-negate/post-negate helper), is instantiated twice: operand magnitude and result correction.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> at N+34: done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high N+1..N+34.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Second start (DIVU 9/3) issued at N+10 during a MULTU 5*6 -> ignored; hi=0, lo=30 at N+34; no second done.
- lo_wen=1, wdata=0x1234 in IDLE -> lo=0x1234 next cycle; same request during CALC -> lo unchanged.
- rst asserted at N+20 mid-DIV -> next cycle busy=0, hi=lo=0, done never pulses; a new start at the following cycle completes normally.
